// File: rtl/map_pkg.sv
// Shared constants for the map scroll renderer.
// Holds the default map geometry, the ROM address width, the fixed pipeline latency,
// the transparent palette index and the 16-entry map palette.
package map_pkg;

   localparam int unsigned DEF_MAP_W  = 640;
   localparam int unsigned DEF_MAP_H  = 480;
   localparam int unsigned DEF_ADDR_W = 19;

   // Input-to-output latency; fixed by the stage structure and not overridable.
   localparam int unsigned PIPE_LAT = 3;

   localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

   // Entry 0 is never displayed: the transparent index shows the background colour instead.
   localparam logic [23:0] MAP_PALETTE [16] = '{
      24'h000000, 24'hf6cd47, 24'hec8039, 24'hed5d1a,
      24'hf03c13, 24'hd03e23, 24'hf20f03, 24'hac2417,
      24'hc80b05, 24'h980604, 24'h760304, 24'h590203,
      24'h3f0102, 24'h270001, 24'h150000, 24'h030000
   };

endpackage

// File: rtl/map_addr_gen.sv
// Stage 1 of the map renderer: adds the camera scroll to the pixel column with a single
// wrap at the map width, forms the row-major ROM address and registers it together with
// the delayed de/hs/vs and an in-map flag for the row.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_de, i_x, i_y          display enable and pixel position
//   i_hs, i_vs              active-low syncs
//   i_scroll                latched camera offset (already < MAP_W)
//   o_rom_addr              registered map ROM address
//   o_de, o_hs, o_vs        syncs delayed one cycle
//   o_inmap                 row lies inside the map image, delayed one cycle
module map_addr_gen
   import map_pkg::*;
#(
   parameter int unsigned MAP_W  = DEF_MAP_W,
   parameter int unsigned MAP_H  = DEF_MAP_H,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_de,
   input  logic [9:0]        i_x,
   input  logic [9:0]        i_y,
   input  logic              i_hs,
   input  logic              i_vs,
   input  logic [9:0]        i_scroll,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic              o_de,
   output logic              o_hs,
   output logic              o_vs,
   output logic              o_inmap
);

   localparam logic [10:0] MAP_W11 = 11'(MAP_W);
   localparam logic [9:0]  MAP_H10 = 10'(MAP_H);

   logic [10:0]       mx_sum;
   logic [10:0]       mx;
   logic [ADDR_W-1:0] addr_d;

   always_comb begin
      mx_sum = {1'b0, i_x} + {1'b0, i_scroll};
      // Scroll is below MAP_W, so one subtraction suffices for columns inside the map.
      mx     = (mx_sum >= MAP_W11) ? (mx_sum - MAP_W11) : mx_sum;
      // Constant multiply; for 640 this reduces to (y<<9)+(y<<7) in synthesis.
      addr_d = ADDR_W'(i_y) * ADDR_W'(MAP_W) + ADDR_W'(mx);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rom_addr <= '0;
         o_de       <= 1'b0;
         o_hs       <= 1'b1;
         o_vs       <= 1'b1;
         o_inmap    <= 1'b0;
      end else begin
         o_rom_addr <= addr_d;
         o_de       <= i_de;
         o_hs       <= i_hs;
         o_vs       <= i_vs;
         o_inmap    <= (i_y < MAP_H10);
      end
   end

endmodule

// File: rtl/map_scroll_renderer.sv
// Pixel stage in front of the VGA DAC. Turns VGA timing into map ROM addresses with a
// per-frame horizontal scroll, resolves the returned 4-bit index through the map palette
// and drives registered RGB with syncs delayed to match (3 cycles input to output).
// Ports:
//   i_clk, i_rst               pixel clock, synchronous active-high reset
//   i_de, i_x, i_y, i_hs, i_vs VGA timing in (syncs active-low)
//   i_frame_start              pulse that latches i_scroll_x
//   i_scroll_x                 requested camera offset; >= MAP_W loads 0
//   i_bg_rgb                   colour for transparent / out-of-map pixels
//   o_rom_addr, i_rom_idx      map ROM address out, registered ROM data back
//   o_r, o_g, o_b              colour out
//   o_hs, o_vs, o_de           timing delayed 3 cycles
//   o_opaque                   displayed pixel came from a non-zero index
module map_scroll_renderer
   import map_pkg::*;
#(
   parameter int unsigned MAP_W  = DEF_MAP_W,
   parameter int unsigned MAP_H  = DEF_MAP_H,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_de,
   input  logic [9:0]        i_x,
   input  logic [9:0]        i_y,
   input  logic              i_hs,
   input  logic              i_vs,
   input  logic              i_frame_start,
   input  logic [9:0]        i_scroll_x,
   input  logic [23:0]       i_bg_rgb,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [3:0]        i_rom_idx,
   output logic [7:0]        o_r,
   output logic [7:0]        o_g,
   output logic [7:0]        o_b,
   output logic              o_hs,
   output logic              o_vs,
   output logic              o_de,
   output logic              o_opaque
);

   localparam logic [10:0] MAP_W11 = 11'(MAP_W);

   logic [9:0]  scroll_q;
   logic        s1_de, s1_hs, s1_vs, s1_inmap;
   logic        s2_de, s2_hs, s2_vs, s2_inmap;
   logic [23:0] rgb_d, rgb_q;
   logic        opaque_d;

   // Camera offset only changes on the frame-start pulse so a frame never tears.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scroll_q <= '0;
      end else if (i_frame_start) begin
         scroll_q <= ({1'b0, i_scroll_x} >= MAP_W11) ? 10'd0 : i_scroll_x;
      end
   end

   map_addr_gen #(
      .MAP_W  (MAP_W),
      .MAP_H  (MAP_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_de       (i_de),
      .i_x        (i_x),
      .i_y        (i_y),
      .i_hs       (i_hs),
      .i_vs       (i_vs),
      .i_scroll   (scroll_q),
      .o_rom_addr (o_rom_addr),
      .o_de       (s1_de),
      .o_hs       (s1_hs),
      .o_vs       (s1_vs),
      .o_inmap    (s1_inmap)
   );

   // Stage 2: the ROM's own output register holds the index, so only sidebands are staged.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_de    <= 1'b0;
         s2_hs    <= 1'b1;
         s2_vs    <= 1'b1;
         s2_inmap <= 1'b0;
      end else begin
         s2_de    <= s1_de;
         s2_hs    <= s1_hs;
         s2_vs    <= s1_vs;
         s2_inmap <= s1_inmap;
      end
   end

   always_comb begin
      rgb_d    = 24'h000000;
      opaque_d = 1'b0;
      if (s2_de) begin
         if (!s2_inmap || (i_rom_idx == TRANSPARENT_IDX)) begin
            rgb_d = i_bg_rgb;
         end else begin
            rgb_d    = MAP_PALETTE[i_rom_idx];
            opaque_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rgb_q    <= 24'h000000;
         o_opaque <= 1'b0;
         o_de     <= 1'b0;
         o_hs     <= 1'b1;
         o_vs     <= 1'b1;
      end else begin
         rgb_q    <= rgb_d;
         o_opaque <= opaque_d;
         o_de     <= s2_de;
         o_hs     <= s2_hs;
         o_vs     <= s2_vs;
      end
   end

   assign o_r = rgb_q[23:16];
   assign o_g = rgb_q[15:8];
   assign o_b = rgb_q[7:0];

endmodule

// File: tb/tb_map_scroll_renderer.sv
module tb_map_scroll_renderer;

   logic        clk = 1'b0;
   logic        i_rst, i_de, i_hs, i_vs, i_frame_start;
   logic [9:0]  i_x, i_y, i_scroll_x;
   logic [23:0] i_bg_rgb;
   logic [18:0] o_rom_addr;
   logic [3:0]  i_rom_idx;
   logic [7:0]  o_r, o_g, o_b;
   logic        o_hs, o_vs, o_de, o_opaque;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   map_scroll_renderer dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_de          (i_de),
      .i_x           (i_x),
      .i_y           (i_y),
      .i_hs          (i_hs),
      .i_vs          (i_vs),
      .i_frame_start (i_frame_start),
      .i_scroll_x    (i_scroll_x),
      .i_bg_rgb      (i_bg_rgb),
      .o_rom_addr    (o_rom_addr),
      .i_rom_idx     (i_rom_idx),
      .o_r           (o_r),
      .o_g           (o_g),
      .o_b           (o_b),
      .o_hs          (o_hs),
      .o_vs          (o_vs),
      .o_de          (o_de),
      .o_opaque      (o_opaque)
   );

   // Reference palette, written out independently of the design package.
   logic [23:0] pal [16] = '{
      24'h000000, 24'hf6cd47, 24'hec8039, 24'hed5d1a, 24'hf03c13, 24'hd03e23,
      24'hf20f03, 24'hac2417, 24'hc80b05, 24'h980604, 24'h760304, 24'h590203,
      24'h3f0102, 24'h270001, 24'h150000, 24'h030000
   };

   // ROM model: hashed contents with per-address overrides for directed tests.
   logic [3:0] rom_ovr [int unsigned];

   function automatic logic [3:0] rom_fn(input int unsigned a);
      logic [31:0] h;
      if (rom_ovr.exists(a)) return rom_ovr[a];
      h = a * 32'd2654435761;
      return h[31:28];
   endfunction

   always @(posedge clk) i_rom_idx <= rom_fn(32'(o_rom_addr));

   typedef struct {
      int unsigned addr;
      logic        de, hs, vs, opq;
      logic [23:0] rgb;
   } exp_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      i_de = 1'b0; i_hs = 1'b1; i_vs = 1'b1; i_frame_start = 1'b0;
   endtask

   task automatic px(input logic de, input int x, input int y);
      i_de = de; i_x = 10'(x); i_y = 10'(y);
      tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_de = 1'b1; i_x = 10'd5; i_y = 10'd5; i_hs = 1'b0; i_vs = 1'b0;
      i_frame_start = 1'b1; i_scroll_x = 10'd300; i_bg_rgb = 24'hffffff;
      tick(); tick();
      n_checks++; if (o_de !== 1'b0) $display("FAIL reset_de got %b want 0", o_de); else n_pass++;
      n_checks++; if ({o_r, o_g, o_b} !== 24'h0) $display("FAIL reset_rgb got %h want 000000", {o_r, o_g, o_b}); else n_pass++;
      n_checks++; if (o_hs !== 1'b1) $display("FAIL reset_hs got %b want 1", o_hs); else n_pass++;
      n_checks++; if (o_vs !== 1'b1) $display("FAIL reset_vs got %b want 1", o_vs); else n_pass++;
      n_checks++; if (o_rom_addr !== 19'd0) $display("FAIL reset_addr got %0d want 0", o_rom_addr); else n_pass++;
      n_checks++; if (o_opaque !== 1'b0) $display("FAIL reset_opaque got %b want 0", o_opaque); else n_pass++;
      // Frame-start during reset must not have loaded the scroll.
      i_rst = 1'b0; set_idle();
      px(1'b1, 0, 0);
      n_checks++; if (o_rom_addr !== 19'd0) $display("FAIL reset_wins_scroll got %0d want 0", o_rom_addr); else n_pass++;
   endtask

   task automatic test_latency();
      set_idle(); repeat (3) tick();
      rom_ovr[1285] = 4'd1;
      i_hs = 1'b0;
      px(1'b1, 5, 2);
      n_checks++; if (o_rom_addr !== 19'd1285) $display("FAIL lat_addr got %0d want 1285", o_rom_addr); else n_pass++;
      set_idle(); tick();
      n_checks++; if (o_hs !== 1'b1) $display("FAIL lat_hs_early got %b want 1", o_hs); else n_pass++;
      n_checks++; if (o_de !== 1'b0) $display("FAIL lat_de_early got %b want 0", o_de); else n_pass++;
      tick();
      n_checks++; if ({o_r, o_g, o_b} !== 24'hf6cd47) $display("FAIL lat_rgb got %h want f6cd47", {o_r, o_g, o_b}); else n_pass++;
      n_checks++; if (o_opaque !== 1'b1) $display("FAIL lat_opaque got %b want 1", o_opaque); else n_pass++;
      n_checks++; if (o_de !== 1'b1) $display("FAIL lat_de got %b want 1", o_de); else n_pass++;
      n_checks++; if (o_hs !== 1'b0) $display("FAIL lat_hs got %b want 0", o_hs); else n_pass++;
      tick();
      n_checks++; if (o_hs !== 1'b1) $display("FAIL lat_hs_after got %b want 1", o_hs); else n_pass++;
   endtask

   task automatic test_wrap();
      set_idle(); i_scroll_x = 10'd600; i_frame_start = 1'b1; tick();
      i_frame_start = 1'b0; i_scroll_x = 10'd0;
      px(1'b1, 50, 1);
      n_checks++; if (o_rom_addr !== 19'd650) $display("FAIL wrap_50 got %0d want 650", o_rom_addr); else n_pass++;
      px(1'b1, 39, 1);
      n_checks++; if (o_rom_addr !== 19'd1279) $display("FAIL wrap_39 got %0d want 1279", o_rom_addr); else n_pass++;
      px(1'b1, 40, 1);
      n_checks++; if (o_rom_addr !== 19'd640) $display("FAIL wrap_40 got %0d want 640", o_rom_addr); else n_pass++;
   endtask

   task automatic test_transparency();
      set_idle(); i_scroll_x = 10'd0; i_frame_start = 1'b1; tick(); set_idle();
      i_bg_rgb = 24'h123456;
      rom_ovr[1930] = 4'd0;
      px(1'b1, 10, 3); set_idle(); tick(); tick();
      n_checks++; if ({o_r, o_g, o_b} !== 24'h123456) $display("FAIL transp_rgb got %h want 123456", {o_r, o_g, o_b}); else n_pass++;
      n_checks++; if (o_opaque !== 1'b0) $display("FAIL transp_opaque got %b want 0", o_opaque); else n_pass++;
      rom_ovr[1930] = 4'd15;
      px(1'b1, 10, 3); set_idle(); tick(); tick();
      n_checks++; if ({o_r, o_g, o_b} !== 24'h030000) $display("FAIL idx15_rgb got %h want 030000", {o_r, o_g, o_b}); else n_pass++;
      n_checks++; if (o_opaque !== 1'b1) $display("FAIL idx15_opaque got %b want 1", o_opaque); else n_pass++;
   endtask

   task automatic test_scroll_gating();
      set_idle(); i_scroll_x = 10'd100;
      px(1'b1, 0, 0);
      n_checks++; if (o_rom_addr !== 19'd0) $display("FAIL gate_nopulse got %0d want 0", o_rom_addr); else n_pass++;
      // The pulse cycle itself still uses the old offset.
      i_frame_start = 1'b1;
      px(1'b1, 0, 0);
      n_checks++; if (o_rom_addr !== 19'd0) $display("FAIL gate_pulse_cycle got %0d want 0", o_rom_addr); else n_pass++;
      i_frame_start = 1'b0;
      px(1'b1, 0, 0);
      n_checks++; if (o_rom_addr !== 19'd100) $display("FAIL gate_after_pulse got %0d want 100", o_rom_addr); else n_pass++;
      i_scroll_x = 10'd700; i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
      px(1'b1, 0, 0);
      n_checks++; if (o_rom_addr !== 19'd0) $display("FAIL gate_oversize got %0d want 0", o_rom_addr); else n_pass++;
      px(1'b1, 639, 479);
      n_checks++; if (o_rom_addr !== 19'd307199) $display("FAIL last_pixel got %0d want 307199", o_rom_addr); else n_pass++;
   endtask

   task automatic test_blank_outmap();
      set_idle(); i_bg_rgb = 24'habcdef;
      px(1'b0, 3, 3); tick(); tick();
      n_checks++; if ({o_r, o_g, o_b} !== 24'h0) $display("FAIL blank_rgb got %h want 000000", {o_r, o_g, o_b}); else n_pass++;
      n_checks++; if (o_de !== 1'b0) $display("FAIL blank_de got %b want 0", o_de); else n_pass++;
      rom_ovr[307200] = 4'd5;
      px(1'b1, 0, 480);
      n_checks++; if (o_rom_addr !== 19'd307200) $display("FAIL outmap_addr got %0d want 307200", o_rom_addr); else n_pass++;
      set_idle(); tick(); tick();
      n_checks++; if ({o_r, o_g, o_b} !== 24'habcdef) $display("FAIL outmap_rgb got %h want abcdef", {o_r, o_g, o_b}); else n_pass++;
      n_checks++; if (o_opaque !== 1'b0) $display("FAIL outmap_opaque got %b want 0", o_opaque); else n_pass++;
   endtask

   task automatic test_reset_midline();
      set_idle(); i_hs = 1'b0;
      px(1'b1, 1, 1); px(1'b1, 2, 1); px(1'b1, 3, 1);
      i_rst = 1'b1; px(1'b1, 4, 1);
      n_checks++; if (o_de !== 1'b0) $display("FAIL midrst_de got %b want 0", o_de); else n_pass++;
      n_checks++; if (o_hs !== 1'b1) $display("FAIL midrst_hs got %b want 1", o_hs); else n_pass++;
      n_checks++; if ({o_r, o_g, o_b} !== 24'h0) $display("FAIL midrst_rgb got %h want 000000", {o_r, o_g, o_b}); else n_pass++;
      i_rst = 1'b0;
      px(1'b1, 5, 1);
      n_checks++; if (o_de !== 1'b0) $display("FAIL postrst_de1 got %b want 0", o_de); else n_pass++;
      px(1'b1, 6, 1);
      n_checks++; if (o_de !== 1'b0) $display("FAIL postrst_de2 got %b want 0", o_de); else n_pass++;
      px(1'b1, 7, 1);
      n_checks++; if (o_de !== 1'b1) $display("FAIL postrst_de3 got %b want 1", o_de); else n_pass++;
      set_idle();
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e, o;
      int unsigned model_scroll;
      int unsigned x, y, sx, mx, idx;
      logic fs;
      rom_ovr.delete();
      set_idle(); i_rst = 1'b1; tick(); i_rst = 1'b0;
      model_scroll = 0;
      for (int b = 0; b < 6; b++) begin
         i_bg_rgb = 24'($urandom);
         q.delete();
         for (int i = 0; i < 50; i++) begin
            x  = $urandom_range(0, 1023);
            y  = $urandom_range(0, 520);
            sx = $urandom_range(0, 1023);
            fs = ($urandom_range(0, 9) == 0);
            e.de = (i < 48) ? 1'($urandom) : 1'b0;
            e.hs = 1'($urandom);
            e.vs = 1'($urandom);
            mx = x + model_scroll;
            if (mx >= 640) mx = mx - 640;
            e.addr = (y * 640 + mx) % 524288;
            idx = rom_fn(e.addr);
            if (!e.de) begin
               e.rgb = 24'h0; e.opq = 1'b0;
            end else if (y >= 480 || idx == 0) begin
               e.rgb = i_bg_rgb; e.opq = 1'b0;
            end else begin
               e.rgb = pal[idx]; e.opq = 1'b1;
            end
            if (fs) model_scroll = (sx >= 640) ? 0 : sx;
            i_de = e.de; i_hs = e.hs; i_vs = e.vs; i_x = 10'(x); i_y = 10'(y);
            i_scroll_x = 10'(sx); i_frame_start = fs;
            q.push_back(e);
            tick();
            n_checks++;
            if (32'(o_rom_addr) !== e.addr)
               $display("FAIL rnd_addr b%0d i%0d got %0d want %0d", b, i, o_rom_addr, e.addr);
            else n_pass++;
            if (q.size() == 3) begin
               o = q.pop_front();
               n_checks++;
               if ({o_r, o_g, o_b} !== o.rgb || o_opaque !== o.opq)
                  $display("FAIL rnd_pix b%0d i%0d got %h/%b want %h/%b", b, i,
                           {o_r, o_g, o_b}, o_opaque, o.rgb, o.opq);
               else n_pass++;
               n_checks++;
               if ({o_de, o_hs, o_vs} !== {o.de, o.hs, o.vs})
                  $display("FAIL rnd_sync b%0d i%0d got %b want %b", b, i,
                           {o_de, o_hs, o_vs}, {o.de, o.hs, o.vs});
               else n_pass++;
            end
         end
      end
      set_idle();
   endtask

   initial begin
      i_rst = 1'b1; i_de = 1'b0; i_hs = 1'b1; i_vs = 1'b1; i_frame_start = 1'b0;
      i_x = '0; i_y = '0; i_scroll_x = '0; i_bg_rgb = '0;
      test_reset();
      test_latency();
      test_wrap();
      test_transparency();
      test_scroll_gating();
      test_blank_outmap();
      test_reset_midline();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
